// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM encoding and flag bundle layout.
package alu_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic carry;
        logic negative;
    } flags_t;

endpackage

// File: rtl/alu_core_comb.sv
// Combinational datapath for opcodes NOP..CMP; SHL is handled by the iterative shifter in alu_pipe.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           add_ovf;
    logic           sub_ovf;
    logic           lt_signed;
    logic [WIDTH-1:0] res;
    flags_t         fl;
    logic           use_res_zn;

    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign diff    = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
    // Signed a<b is N xor V of the subtraction.
    assign lt_signed = diff[WIDTH-1] ^ sub_ovf;

    always_comb begin
        res        = '0;
        fl         = '0;
        use_res_zn = 1'b0;
        case (op_i)
            OP_ADD: begin
                res         = sum[WIDTH-1:0];
                fl.carry    = sum[WIDTH];
                fl.overflow = add_ovf;
                use_res_zn  = 1'b1;
            end
            OP_SUB: begin
                res         = diff[WIDTH-1:0];
                fl.carry    = diff[WIDTH];
                fl.overflow = sub_ovf;
                use_res_zn  = 1'b1;
            end
            OP_AND: begin
                res        = a_i & b_i;
                use_res_zn = 1'b1;
            end
            OP_OR: begin
                res        = a_i | b_i;
                use_res_zn = 1'b1;
            end
            OP_XOR: begin
                res        = a_i ^ b_i;
                use_res_zn = 1'b1;
            end
            OP_CMP: begin
                res         = {{(WIDTH-2){1'b0}}, lt_signed, (a_i == b_i)};
                fl.zero     = (diff[WIDTH-1:0] == '0);
                fl.negative = diff[WIDTH-1];
                fl.carry    = diff[WIDTH];
                fl.overflow = sub_ovf;
            end
            default: begin
                res = '0;
            end
        endcase
        if (use_res_zn) begin
            fl.zero     = (res == '0);
            fl.negative = res[WIDTH-1];
        end
    end

    assign result_o = res;
    assign flags_o  = fl;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, a one-bit-per-cycle left shifter and a sticky overflow flag.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             negative,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    state_t           state_q;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             sticky_q;

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;
    logic             out_free;
    logic             accept;
    logic             is_shl;
    logic [SHW-1:0]   n;
    logic             shift_step;
    logic             wr_en;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    assign out_free   = !out_valid_q || out_ready;
    assign in_ready   = (state_q == ST_IDLE) && out_free;
    assign accept     = in_valid && in_ready;
    assign is_shl     = (op == OP_SHL);
    assign n          = b[SHW-1:0];
    assign shift_step = (state_q == ST_SHIFT) && out_free;

    assign sh_d  = sh_q << 1;
    assign cnt_d = cnt_q - SHW'(1);
    assign c_d   = shift_step ? sh_q[WIDTH-1] : c_q;

    always_comb begin
        wr_en    = 1'b0;
        result_d = core_result;
        flags_d  = flags_t'(core_flags);
        if (accept) begin
            if (!is_shl) begin
                wr_en = 1'b1;
            end else if (n == '0) begin
                wr_en            = 1'b1;
                result_d         = a;
                flags_d          = '0;
                flags_d.zero     = (a == '0);
                flags_d.negative = a[WIDTH-1];
            end
        end else if (shift_step && (cnt_q == SHW'(1))) begin
            // Final shift: the bit leaving the MSB now is the carry.
            wr_en            = 1'b1;
            result_d         = sh_d;
            flags_d          = '0;
            flags_d.zero     = (sh_d == '0);
            flags_d.negative = sh_d[WIDTH-1];
            flags_d.carry    = c_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            sticky_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_shl && (n != '0)) begin
                        sh_q    <= a;
                        cnt_q   <= n;
                        c_q     <= 1'b0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (shift_step) begin
                        sh_q  <= sh_d;
                        cnt_q <= cnt_d;
                        c_q   <= c_d;
                        if (cnt_q == SHW'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (wr_en) begin
                result_q    <= result_d;
                flags_q     <= flags_d;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (wr_en && flags_d.overflow) begin
                sticky_q <= 1'b1;
            end else if (clr_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = flags_q.zero;
    assign overflow   = flags_q.overflow;
    assign carry      = flags_q.carry;
    assign negative   = flags_q.negative;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_sticky = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero, overflow, carry, negative, sticky_ovf;

    int   checks = 0;
    int   failures = 0;
    logic sticky_exp = 1'b0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .carry      (carry),
        .negative   (negative),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs_flags();
        return {zero, overflow, carry, negative};
    endfunction

    // Reference: flags returned as {zero, overflow, carry, negative}.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f);
        longint sx, sy, s;
        logic   z, v, c, ng;
        int     sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v = 1'b0;
        c = 1'b0;
        r = 32'd0;
        case (o)
            3'd1: begin
                s = sx + sy;
                r = x + y;
                c = (({32'd0, x} + {32'd0, y}) > 64'h00000000FFFFFFFF);
                v = (s > MAXS) || (s < MINS);
            end
            3'd2, 3'd6: begin
                s = sx - sy;
                r = x - y;
                c = (x >= y);
                v = (s > MAXS) || (s < MINS);
            end
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd7: begin
                sh = int'(y[4:0]);
                r  = x << sh;
                c  = (sh == 0) ? 1'b0 : x[32-sh];
            end
            default: r = 32'd0;
        endcase
        z  = (r == 32'd0);
        ng = r[31];
        if (o == 3'd6) r = {30'd0, (sx < sy), (x == y)};
        f = (o == 3'd0) ? 4'b0000 : {z, v, c, ng};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        model(o, x, y, r, f);
        lat = (o == 3'd7) ? int'(y[4:0]) : 0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        if (f[2]) sticky_exp = 1'b1;
        else if (clr_sticky) sticky_exp = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            chk({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".busy_out_valid"}, 32'(out_valid), 32'd0);
            step();
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, result, r);
        chk({tag, ".flags"}, 32'(obs_flags()), 32'(f));
        chk({tag, ".sticky"}, 32'(sticky_ovf), 32'(sticky_exp));
        $display("txn %s op=%0d a=%08h b=%08h result=%08h zvcn=%b sticky=%b",
                 tag, o, x, y, result, obs_flags(), sticky_ovf);
    endtask

    initial begin
        logic        stale;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic [31:0] er;
        logic [3:0]  ef;

        repeat (3) step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.flags", 32'(obs_flags()), 32'd0);
        chk("rst.sticky", 32'(sticky_ovf), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        run_op("add_ovf", 3'd1, 32'h7FFFFFFF, 32'h00000001);
        chk("add_ovf.const_res", result, 32'h80000000);
        chk("add_ovf.const_flags", 32'(obs_flags()), 32'b0101);
        chk("add_ovf.const_sticky", 32'(sticky_ovf), 32'd1);

        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        sticky_exp = 1'b0;
        chk("clr.sticky", 32'(sticky_ovf), 32'd0);
        chk("clr.consumed", 32'(out_valid), 32'd0);

        run_op("sub_eq", 3'd2, 32'd5, 32'd5);
        chk("sub_eq.const_flags", 32'(obs_flags()), 32'b1010);
        run_op("cmp", 3'd6, 32'hFFFFFFFF, 32'h00000001);
        chk("cmp.const_res", result, 32'h00000002);
        chk("cmp.const_flags", 32'(obs_flags()), 32'b0011);
        run_op("shl4", 3'd7, 32'h90000001, 32'd4);
        chk("shl4.const_res", result, 32'h00000010);
        chk("shl4.const_carry", 32'(carry), 32'd1);

        run_op("b2b_xor", 3'd5, 32'hA5A5F0F0, 32'h0FF00FF0);
        run_op("b2b_and", 3'd3, 32'hA5A5F0F0, 32'h0FF00FF0);
        run_op("b2b_or", 3'd4, 32'hA5A5F0F0, 32'h0FF00FF0);
        run_op("nop", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("nop.const_res", result, 32'd0);
        step();

        // Pending result held under back-pressure, then delivered ahead of the next one.
        out_ready = 1'b0;
        run_op("bp_add", 3'd1, 32'd1, 32'd2);
        op = 3'd5;
        a = 32'h000000FF;
        b = 32'h0000000F;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_result", result, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_in_ready", 32'(in_ready), 32'd1);
        chk("bp.release_result", result, 32'd3);
        step();
        in_valid = 1'b0;
        chk("bp.next_valid", 32'(out_valid), 32'd1);
        chk("bp.next_result", result, 32'h000000F0);
        step();

        out_ready = 1'b0;
        run_op("bp_shl", 3'd7, 32'h00000003, 32'd6);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_shl.hold_result", result, 32'h000000C0);
            chk("bp_shl.hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_shl.consumed", 32'(out_valid), 32'd0);

        // Reset asserted in the middle of a 20-step shift.
        op = 3'd7;
        a = 32'h12345678;
        b = 32'd20;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        sticky_exp = 1'b0;
        #1;
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            stale = stale | out_valid;
        end
        chk("midrst.no_stale", 32'(stale), 32'd0);
        chk("midrst.sticky", 32'(sticky_ovf), 32'd0);

        clr_sticky = 1'b1;
        run_op("clr_vs_set", 3'd2, 32'h80000000, 32'h00000001);
        clr_sticky = 1'b0;
        chk("clr_vs_set.const_sticky", 32'(sticky_ovf), 32'd1);

        run_op("shl0", 3'd7, 32'h80000000, 32'hFFFFFFE0);
        run_op("shl31", 3'd7, 32'h00000003, 32'd31);

        for (int t = 0; t < 60; t++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            if ((t % 5) == 0) ry = rx;
            if ((t % 7) == 0) rx = 32'h80000000;
            model(ro, rx, ry, er, ef);
            run_op($sformatf("rnd%0d", t), ro, rx, ry);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
